// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the address-phase bundle used by the two-master arbiter.
package ahb_pkg;

  localparam int AHB_AW = 32;
  localparam int AHB_DW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic [1:0]        trans;
    logic [AHB_AW-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [2:0]        burst;
    logic [3:0]        prot;
    logic              lock;
  } ahb_addr_t;

endpackage

// File: rtl/ahb_addr_hold.sv
// One-deep holding register for an address phase that was accepted but lost arbitration.
module ahb_addr_hold
  import ahb_pkg::*;
(
  input  logic      HCLK,
  input  logic      HRESET,
  input  logic      load,
  input  logic      clear,
  input  ahb_addr_t d,
  output ahb_addr_t q,
  output logic      vld
);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= 1'b1;
      q   <= d;
    end else if (clear) begin
      vld <= 1'b0;
    end
  end

endmodule

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter onto one slave port: round-robin grant with lock/SEQ holding,
// loser address phases parked in a pending register, data-phase routing by data_owner.
module ahb_master_arbiter
  import ahb_pkg::*;
#(
  parameter int AW = AHB_AW,
  parameter int DW = AHB_DW
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic [1:0]    M0_HTRANS,
  input  logic [AW-1:0] M0_HADDR,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [2:0]    M0_HBURST,
  input  logic [3:0]    M0_HPROT,
  input  logic          M0_HMASTLOCK,
  input  logic [DW-1:0] M0_HWDATA,
  output logic          M0_HREADY,
  output logic          M0_HRESP,
  output logic [DW-1:0] M0_HRDATA,
  input  logic [1:0]    M1_HTRANS,
  input  logic [AW-1:0] M1_HADDR,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [2:0]    M1_HBURST,
  input  logic [3:0]    M1_HPROT,
  input  logic          M1_HMASTLOCK,
  input  logic [DW-1:0] M1_HWDATA,
  output logic          M1_HREADY,
  output logic          M1_HRESP,
  output logic [DW-1:0] M1_HRDATA,
  output logic          S_HSEL,
  output logic [1:0]    S_HTRANS,
  output logic [AW-1:0] S_HADDR,
  output logic          S_HWRITE,
  output logic [2:0]    S_HSIZE,
  output logic [2:0]    S_HBURST,
  output logic [3:0]    S_HPROT,
  output logic          S_HMASTLOCK,
  output logic [DW-1:0] S_HWDATA,
  output logic          S_HREADY,
  input  logic          S_HREADYOUT,
  input  logic          S_HRESP,
  input  logic [DW-1:0] S_HRDATA
);

  ahb_addr_t  live [2];
  ahb_addr_t  pend [2];
  ahb_addr_t  sel;
  logic [1:0] pend_vld;
  logic [1:0] hready;
  logic [1:0] req_live;
  logic [1:0] req;
  logic [1:0] load;
  logic [1:0] clear;
  logic       gnt_vld;
  logic       gnt;
  logic       hold;
  logic       last_grant;
  logic       lock_q;
  logic       data_owner;
  logic       dvld;

  assign live[0] = {M0_HTRANS, M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK};
  assign live[1] = {M1_HTRANS, M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK};

  // The data owner waits on the slave; a master with a parked address is stalled until it drains.
  assign hready[0] = (dvld && !data_owner) ? S_HREADYOUT : !pend_vld[0];
  assign hready[1] = (dvld &&  data_owner) ? S_HREADYOUT : !pend_vld[1];

  assign req_live[0] = live[0].trans[1] & hready[0];
  assign req_live[1] = live[1].trans[1] & hready[1];
  assign req         = pend_vld | req_live;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = last_grant;
    hold    = (lock_q || live[last_grant].trans == HTRANS_SEQ) && req[last_grant];
    if (S_HREADYOUT && (|req)) begin
      gnt_vld = 1'b1;
      if (hold)          gnt = last_grant;
      else if (&req)     gnt = ~last_grant;
      else               gnt = req[1];
    end
    sel = pend_vld[gnt] ? pend[gnt] : live[gnt];
  end

  // Any accepted live request that is not forwarded this cycle must be parked, including during stalls.
  always_comb begin
    load  = '0;
    clear = '0;
    for (int i = 0; i < 2; i++) begin
      load[i]  = req_live[i] && !(gnt_vld && gnt == 1'(i));
      clear[i] = pend_vld[i] && gnt_vld && gnt == 1'(i);
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_hold
    ahb_addr_hold u_hold (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .load   (load[g]),
      .clear  (clear[g]),
      .d      (live[g]),
      .q      (pend[g]),
      .vld    (pend_vld[g])
    );
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      last_grant <= 1'b1;
      lock_q     <= 1'b0;
      dvld       <= 1'b0;
      data_owner <= 1'b0;
    end else if (S_HREADYOUT) begin
      dvld <= gnt_vld;
      if (gnt_vld) begin
        data_owner <= gnt;
        last_grant <= gnt;
        lock_q     <= sel.lock;
      end
    end
  end

  assign S_HSEL      = gnt_vld;
  assign S_HTRANS    = gnt_vld ? sel.trans : HTRANS_IDLE;
  assign S_HADDR     = sel.addr;
  assign S_HWRITE    = sel.write;
  assign S_HSIZE     = sel.size;
  assign S_HBURST    = sel.burst;
  assign S_HPROT     = sel.prot;
  assign S_HMASTLOCK = sel.lock;
  assign S_HWDATA    = data_owner ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY    = S_HREADYOUT;

  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRESP  = (dvld && !data_owner) ? S_HRESP : HRESP_OKAY;
  assign M1_HRESP  = (dvld &&  data_owner) ? S_HRESP : HRESP_OKAY;
  assign M0_HRDATA = (dvld && !data_owner) ? S_HRDATA : '0;
  assign M1_HRDATA = (dvld &&  data_owner) ? S_HRDATA : '0;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: reset, single and contended transfers, lock, wait/ERROR, reset mid-flight.
module tb_ahb_master_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR;
  logic        M0_HWRITE, M1_HWRITE;
  logic [2:0]  M0_HSIZE, M1_HSIZE, M0_HBURST, M1_HBURST;
  logic [3:0]  M0_HPROT, M1_HPROT;
  logic        M0_HMASTLOCK, M1_HMASTLOCK;
  logic [31:0] M0_HWDATA, M1_HWDATA;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        S_HSEL, S_HWRITE, S_HMASTLOCK, S_HREADY;
  logic [1:0]  S_HTRANS;
  logic [31:0] S_HADDR, S_HWDATA;
  logic [2:0]  S_HSIZE, S_HBURST;
  logic [3:0]  S_HPROT;
  logic        S_HREADYOUT, S_HRESP;
  logic [31:0] S_HRDATA;

  int tests = 0;
  int failed = 0;
  logic [31:0] exp_q[$];

  always #5 HCLK = ~HCLK;

  ahb_master_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HBURST(M0_HBURST), .M0_HPROT(M0_HPROT), .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA),
    .M0_HREADY(M0_HREADY), .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HBURST(M1_HBURST), .M1_HPROT(M1_HPROT), .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA),
    .M1_HREADY(M1_HREADY), .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HBURST(S_HBURST), .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA),
    .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    if (m == 0) begin
      M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HMASTLOCK = l;
    end else begin
      M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HMASTLOCK = l;
    end
  endtask

  task automatic slv(input logic rdy, input logic rsp, input logic [31:0] rd);
    S_HREADYOUT = rdy; S_HRESP = rsp; S_HRDATA = rd;
  endtask

  // Advance one full cycle: returns at the next falling edge, after the rising edge has updated state.
  task automatic step();
    @(negedge HCLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    logic        r0, r1;
    int          i0, i1;

    M0_HSIZE = 3'b010; M1_HSIZE = 3'b010; M0_HBURST = 3'b000; M1_HBURST = 3'b000;
    M0_HPROT = 4'b0011; M1_HPROT = 4'b0011; M0_HWDATA = '0; M1_HWDATA = '0;
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    slv(1'b1, 1'b0, 32'h5555_5555);

    // Reset state
    step(); step();
    #2;
    chk("rst_m0_hready", 32'(M0_HREADY), 32'd1);
    chk("rst_m1_hready", 32'(M1_HREADY), 32'd1);
    chk("rst_s_htrans", 32'(S_HTRANS), 32'd0);
    chk("rst_s_hsel", 32'(S_HSEL), 32'd0);
    chk("rst_m0_hrdata", M0_HRDATA, 32'd0);
    chk("rst_m1_hresp", 32'(M1_HRESP), 32'd0);
    step();
    HRESET = 1'b0;

    // Single M0 write: zero-latency address, write data routed next cycle
    drv(0, 2'b10, 32'h0000_1000, 1'b1, 1'b0);
    M1_HWDATA = 32'h1111_1111;
    #2;
    chk("w_s_haddr", S_HADDR, 32'h0000_1000);
    chk("w_s_htrans", 32'(S_HTRANS), 32'd2);
    chk("w_s_hwrite", 32'(S_HWRITE), 32'd1);
    chk("w_m0_hready", 32'(M0_HREADY), 32'd1);
    step();
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    M0_HWDATA = 32'hDEAD_BEEF;
    #2;
    chk("w_s_hwdata", S_HWDATA, 32'hDEAD_BEEF);
    chk("w_m0_hready_dp", 32'(M0_HREADY), 32'd1);
    chk("w_s_hsel_idle", 32'(S_HSEL), 32'd0);
    step();

    // Reset, then simultaneous reads from both masters
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    drv(0, 2'b10, 32'h10, 1'b0, 1'b0);
    drv(1, 2'b10, 32'h20, 1'b0, 1'b0);
    #2;
    chk("rr_first_addr", S_HADDR, 32'h10);
    chk("rr_m1_hready_t0", 32'(M1_HREADY), 32'd1);
    step();
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    slv(1'b1, 1'b0, 32'hA);
    #2;
    chk("rr_second_addr", S_HADDR, 32'h20);
    chk("rr_second_trans", 32'(S_HTRANS), 32'd2);
    chk("rr_m1_hready_t1", 32'(M1_HREADY), 32'd0);
    chk("rr_m0_hrdata", M0_HRDATA, 32'hA);
    chk("rr_m1_hrdata_t1", M1_HRDATA, 32'h0);
    step();
    slv(1'b1, 1'b0, 32'hB);
    #2;
    chk("rr_m1_hready_t2", 32'(M1_HREADY), 32'd1);
    chk("rr_m1_hrdata", M1_HRDATA, 32'hB);
    chk("rr_m0_hrdata_t2", M0_HRDATA, 32'h0);
    chk("rr_idle_t2", 32'(S_HTRANS), 32'd0);
    step();
    step();

    // Four back-to-back reads from each master: strict alternation, none lost or repeated
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'h100 + 32'(4 * k));
      exp_q.push_back(32'h200 + 32'(4 * k));
    end
    i0 = 0; i1 = 0;
    for (int c = 0; c < 14; c++) begin
      drv(0, (i0 < 4) ? 2'b10 : 2'b00, 32'h100 + 32'(4 * i0), 1'b0, 1'b0);
      drv(1, (i1 < 4) ? 2'b10 : 2'b00, 32'h200 + 32'(4 * i1), 1'b0, 1'b0);
      #2;
      if (S_HTRANS == 2'b10) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        chk("b2b_order", S_HADDR, e);
      end
      r0 = M0_HREADY;
      r1 = M1_HREADY;
      step();
      if (r0 && i0 < 4) i0++;
      if (r1 && i1 < 4) i1++;
    end
    chk("b2b_left", 32'(exp_q.size()), 32'd0);
    chk("b2b_m0_done", 32'(i0), 32'd4);
    chk("b2b_m1_done", 32'(i1), 32'd4);

    // M1 locked sequence of three NONSEQ transfers while M0 contends
    drv(1, 2'b10, 32'h300, 1'b0, 1'b1);
    #2;
    chk("lk_a_addr", S_HADDR, 32'h300);
    chk("lk_a_lock", 32'(S_HMASTLOCK), 32'd1);
    step();
    drv(1, 2'b10, 32'h304, 1'b0, 1'b1);
    drv(0, 2'b10, 32'h400, 1'b0, 1'b0);
    #2;
    chk("lk_b_addr", S_HADDR, 32'h304);
    chk("lk_b_m0_hready", 32'(M0_HREADY), 32'd1);
    step();
    drv(1, 2'b10, 32'h308, 1'b0, 1'b1);
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    #2;
    chk("lk_c_addr", S_HADDR, 32'h308);
    chk("lk_c_m0_hready", 32'(M0_HREADY), 32'd0);
    step();
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    #2;
    chk("lk_d_addr", S_HADDR, 32'h400);
    chk("lk_d_trans", 32'(S_HTRANS), 32'd2);
    chk("lk_d_lock", 32'(S_HMASTLOCK), 32'd0);
    step();
    #2;
    chk("lk_e_idle", 32'(S_HTRANS), 32'd0);
    chk("lk_e_m0_hready", 32'(M0_HREADY), 32'd1);
    step();

    // Two wait states then a two-cycle ERROR on M0 while M1 is parked
    drv(0, 2'b10, 32'h500, 1'b0, 1'b0);
    #2;
    chk("er_a_addr", S_HADDR, 32'h500);
    step();
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drv(1, 2'b10, 32'h600, 1'b0, 1'b0);
    slv(1'b0, 1'b0, 32'h0);
    #2;
    chk("er_b_idle", 32'(S_HTRANS), 32'd0);
    chk("er_b_m0_hready", 32'(M0_HREADY), 32'd0);
    chk("er_b_m1_hready", 32'(M1_HREADY), 32'd1);
    step();
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    #2;
    chk("er_c_m1_hready", 32'(M1_HREADY), 32'd0);
    chk("er_c_idle", 32'(S_HTRANS), 32'd0);
    step();
    slv(1'b0, 1'b1, 32'h0);
    #2;
    chk("er_d_m0_hresp", 32'(M0_HRESP), 32'd1);
    chk("er_d_m1_hresp", 32'(M1_HRESP), 32'd0);
    chk("er_d_m0_hready", 32'(M0_HREADY), 32'd0);
    step();
    slv(1'b1, 1'b1, 32'h0);
    #2;
    chk("er_e_m0_hresp", 32'(M0_HRESP), 32'd1);
    chk("er_e_m0_hready", 32'(M0_HREADY), 32'd1);
    chk("er_e_m1_hresp", 32'(M1_HRESP), 32'd0);
    chk("er_e_m1_hready", 32'(M1_HREADY), 32'd0);
    chk("er_e_addr", S_HADDR, 32'h600);
    chk("er_e_trans", 32'(S_HTRANS), 32'd2);
    step();
    slv(1'b0, 1'b0, 32'h0);
    #2;
    chk("er_f_m1_hready", 32'(M1_HREADY), 32'd0);
    chk("er_f_m0_hresp", 32'(M0_HRESP), 32'd0);
    step();
    slv(1'b1, 1'b0, 32'h66);
    #2;
    chk("er_g_m1_hready", 32'(M1_HREADY), 32'd1);
    chk("er_g_m1_hrdata", M1_HRDATA, 32'h66);
    step();
    slv(1'b1, 1'b0, 32'h0);
    step();

    // Reset while M1 is parked and M0 is in a stalled data phase
    drv(0, 2'b10, 32'h700, 1'b0, 1'b0);
    #2;
    chk("rs_a_addr", S_HADDR, 32'h700);
    step();
    drv(0, 2'b00, 32'h0, 1'b0, 1'b0);
    drv(1, 2'b10, 32'h800, 1'b0, 1'b0);
    slv(1'b0, 1'b0, 32'h0);
    step();
    drv(1, 2'b00, 32'h0, 1'b0, 1'b0);
    HRESET = 1'b1;
    #2;
    chk("rs_c_m1_hready", 32'(M1_HREADY), 32'd0);
    step();
    HRESET = 1'b0;
    slv(1'b1, 1'b0, 32'h0);
    #2;
    chk("rs_d_idle", 32'(S_HTRANS), 32'd0);
    chk("rs_d_hsel", 32'(S_HSEL), 32'd0);
    chk("rs_d_m0_hready", 32'(M0_HREADY), 32'd1);
    chk("rs_d_m1_hready", 32'(M1_HREADY), 32'd1);
    step();
    #2;
    chk("rs_e_idle", 32'(S_HTRANS), 32'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
